// File: rtl/rom_fetch_arbiter_if.sv
// Shared ROM/SDRAM read port: request/address out, ack/data back.
interface rom_fetch_arbiter_if #(
  parameter int unsigned MEM_AW = 22
);
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Arbitrates the 68000 program-ROM and Z80 sound-ROM windows onto one 16-bit
// memory read port. Each side keeps a one-word tag cache; ties go round-robin.
module rom_fetch_arbiter #(
  parameter int unsigned       MEM_AW    = 22,
  parameter logic [MEM_AW-1:0] M68K_BASE = 22'h000000,
  parameter logic [MEM_AW-1:0] Z80_BASE  = 22'h010000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 inval,
  input  logic                 m68k_rom_cs,
  input  logic [15:0]          m68k_addr,
  output logic [15:0]          m68k_dout,
  output logic                 m68k_rom_ok,
  input  logic                 z80_rom_cs,
  input  logic [15:0]          z80_addr,
  output logic [7:0]           z80_dout,
  output logic                 z80_rom_ok,
  rom_fetch_arbiter_if.master  mem
);

  typedef enum logic [1:0] {StIdle, StFetchM68k, StFetchZ80} state_e;

  // rr names the requester granted last
  localparam logic RrM68k = 1'b0;
  localparam logic RrZ80  = 1'b1;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              discard_q, discard_d;
  logic              mem_req_q, mem_req_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       lat_tag_q, lat_tag_d;
  logic [15:0]       m68k_tag_q, m68k_tag_d;
  logic [15:0]       m68k_data_q, m68k_data_d;
  logic              m68k_valid_q, m68k_valid_d;
  logic [14:0]       z80_tag_q, z80_tag_d;
  logic [15:0]       z80_data_q, z80_data_d;
  logic              z80_valid_q, z80_valid_d;
  logic              m68k_ok_q, m68k_ok_d;
  logic              z80_ok_q, z80_ok_d;

  logic m68k_hit, z80_hit, m68k_pend, z80_pend;
  logic grant_m68k, grant_z80;
  logic ack_m68k, ack_z80, fill_ok;

  assign m68k_hit   = m68k_rom_cs & m68k_valid_q & (m68k_tag_q == m68k_addr);
  assign z80_hit    = z80_rom_cs & z80_valid_q & (z80_tag_q == z80_addr[15:1]);
  assign m68k_pend  = m68k_rom_cs & ~m68k_hit;
  assign z80_pend   = z80_rom_cs & ~z80_hit;
  assign grant_m68k = m68k_pend & (~z80_pend | (rr_q == RrZ80));
  assign grant_z80  = z80_pend & ~grant_m68k;
  assign ack_m68k   = (state_q == StFetchM68k) & mem.mem_ack;
  assign ack_z80    = (state_q == StFetchZ80) & mem.mem_ack;
  // A fill only becomes valid if no invalidate hit this fetch or this edge
  assign fill_ok    = ~discard_q & ~inval;

  // Next-state: arbitration, cache fill and invalidation
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    discard_d    = discard_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    lat_tag_d    = lat_tag_q;
    m68k_tag_d   = m68k_tag_q;
    m68k_data_d  = m68k_data_q;
    m68k_valid_d = m68k_valid_q;
    z80_tag_d    = z80_tag_q;
    z80_data_d   = z80_data_q;
    z80_valid_d  = z80_valid_q;

    case (state_q)
      StIdle: begin
        if (grant_m68k) begin
          state_d    = StFetchM68k;
          mem_req_d  = 1'b1;
          mem_addr_d = M68K_BASE + MEM_AW'(m68k_addr);
          lat_tag_d  = m68k_addr;
          rr_d       = RrM68k;
        end else if (grant_z80) begin
          state_d    = StFetchZ80;
          mem_req_d  = 1'b1;
          mem_addr_d = Z80_BASE + MEM_AW'(z80_addr[15:1]);
          lat_tag_d  = {1'b0, z80_addr[15:1]};
          rr_d       = RrZ80;
        end
      end
      StFetchM68k: begin
        if (mem.mem_ack) begin
          m68k_data_d  = mem.mem_data;
          m68k_tag_d   = lat_tag_q;
          m68k_valid_d = fill_ok;
          mem_req_d    = 1'b0;
          discard_d    = 1'b0;
          state_d      = StIdle;
        end
      end
      StFetchZ80: begin
        if (mem.mem_ack) begin
          z80_data_d  = mem.mem_data;
          z80_tag_d   = lat_tag_q[14:0];
          z80_valid_d = fill_ok;
          mem_req_d   = 1'b0;
          discard_d   = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (inval) begin
      m68k_valid_d = 1'b0;
      z80_valid_d  = 1'b0;
      // Mark an in-flight fetch stale unless it is completing on this edge
      if ((state_q != StIdle) && !mem.mem_ack) begin
        discard_d = 1'b1;
      end
    end
  end

  // ok covers both a cache hit and a fill landing for the current address
  always_comb begin
    m68k_ok_d = ~inval & m68k_rom_cs &
                (m68k_hit | (ack_m68k & ~discard_q & (lat_tag_q == m68k_addr)));
    z80_ok_d  = ~inval & z80_rom_cs &
                (z80_hit | (ack_z80 & ~discard_q & (lat_tag_q[14:0] == z80_addr[15:1])));
  end

  // State and cache registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rr_q         <= RrZ80;
      discard_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      lat_tag_q    <= '0;
      m68k_tag_q   <= '0;
      m68k_data_q  <= '0;
      m68k_valid_q <= 1'b0;
      z80_tag_q    <= '0;
      z80_data_q   <= '0;
      z80_valid_q  <= 1'b0;
      m68k_ok_q    <= 1'b0;
      z80_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      discard_q    <= discard_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      lat_tag_q    <= lat_tag_d;
      m68k_tag_q   <= m68k_tag_d;
      m68k_data_q  <= m68k_data_d;
      m68k_valid_q <= m68k_valid_d;
      z80_tag_q    <= z80_tag_d;
      z80_data_q   <= z80_data_d;
      z80_valid_q  <= z80_valid_d;
      m68k_ok_q    <= m68k_ok_d;
      z80_ok_q     <= z80_ok_d;
    end
  end

  assign m68k_dout    = m68k_data_q;
  assign z80_dout     = z80_addr[0] ? z80_data_q[15:8] : z80_data_q[7:0];
  assign m68k_rom_ok  = m68k_ok_q;
  assign z80_rom_ok   = z80_ok_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench: stimulus queues expected requests and CPU responses; negedge
// monitors pop and compare when the DUT raises mem_req or an ok flag.
module tb_rom_fetch_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        inval;
  logic        m68k_rom_cs;
  logic [15:0] m68k_addr;
  logic [15:0] m68k_dout;
  logic        m68k_rom_ok;
  logic        z80_rom_cs;
  logic [15:0] z80_addr;
  logic [7:0]  z80_dout;
  logic        z80_rom_ok;

  rom_fetch_arbiter_if #(.MEM_AW(22)) mem_if ();

  rom_fetch_arbiter dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .inval       (inval),
    .m68k_rom_cs (m68k_rom_cs),
    .m68k_addr   (m68k_addr),
    .m68k_dout   (m68k_dout),
    .m68k_rom_ok (m68k_rom_ok),
    .z80_rom_cs  (z80_rom_cs),
    .z80_addr    (z80_addr),
    .z80_dout    (z80_dout),
    .z80_rom_ok  (z80_rom_ok),
    .mem         (mem_if)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { logic [15:0] a; logic [15:0] d; } cpu_exp_t;
  typedef struct { int unsigned dly; logic [15:0] d; } resp_t;

  cpu_exp_t    m_q[$];
  cpu_exp_t    z_q[$];
  logic [21:0] req_q[$];
  resp_t       resp_q[$];
  int          req_rise_cyc[$];
  int          ack_cyc[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Memory responder and request monitor
  logic        req_last = 1'b0;
  logic        busy     = 1'b0;
  int unsigned wait_cnt = 0;
  logic [15:0] data_pend;
  logic [21:0] req_cap;
  logic [21:0] req_exp;
  resp_t       r_cur;

  always @(negedge clk_sys) begin
    if (mem_if.mem_ack) mem_if.mem_ack = 1'b0;
    if (mem_if.mem_req && !req_last) begin
      req_rise_cyc.push_back(cyc);
      if (req_q.size() == 0) begin
        check("mem_req_unexpected", {10'd0, mem_if.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        req_exp = req_q.pop_front();
        check("mem_addr", {10'd0, mem_if.mem_addr}, {10'd0, req_exp});
      end
      req_cap = mem_if.mem_addr;
      if (resp_q.size() != 0) begin
        r_cur     = resp_q.pop_front();
        wait_cnt  = r_cur.dly;
        data_pend = r_cur.d;
        busy      = 1'b1;
      end
    end
    if (busy) begin
      if (wait_cnt == 0) begin
        mem_if.mem_ack  = 1'b1;
        mem_if.mem_data = data_pend;
        busy            = 1'b0;
        ack_cyc.push_back(cyc);
        if (mem_if.mem_req) check("mem_addr_stable", {10'd0, mem_if.mem_addr}, {10'd0, req_cap});
      end else begin
        wait_cnt--;
      end
    end
    req_last = mem_if.mem_req;
  end

  // CPU-side monitor: a new ok (or ok for a new address) pops one expectation
  logic        m_ok_last = 1'b0;
  logic        z_ok_last = 1'b0;
  logic [15:0] m_a_prev = '0, m_key = '0;
  logic [15:0] z_a_prev = '0, z_key = '0;
  cpu_exp_t    m_cur, z_cur;

  always @(negedge clk_sys) begin
    if (m68k_rom_ok && (!m_ok_last || m_a_prev != m_key)) begin
      if (m_q.size() == 0) begin
        check("m68k_ok_unexpected", {16'd0, m_a_prev}, 32'hFFFF_FFFF);
      end else begin
        m_cur = m_q.pop_front();
        check("m68k_ok_addr", {16'd0, m_a_prev}, {16'd0, m_cur.a});
        check("m68k_dout", {16'd0, m68k_dout}, {16'd0, m_cur.d});
      end
      m_key = m_a_prev;
    end
    if (z80_rom_ok && (!z_ok_last || z_a_prev != z_key)) begin
      if (z_q.size() == 0) begin
        check("z80_ok_unexpected", {16'd0, z_a_prev}, 32'hFFFF_FFFF);
      end else begin
        z_cur = z_q.pop_front();
        check("z80_ok_addr", {16'd0, z_a_prev}, {16'd0, z_cur.a});
        check("z80_dout", {24'd0, z80_dout}, {16'd0, z_cur.d});
      end
      z_key = z_a_prev;
    end
    m_ok_last = m68k_rom_ok;
    z_ok_last = z80_rom_ok;
    m_a_prev  = m68k_addr;
    z_a_prev  = z80_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset_n         = 1'b0;
    inval           = 1'b0;
    m68k_rom_cs     = 1'b0;
    m68k_addr       = '0;
    z80_rom_cs      = 1'b0;
    z80_addr        = '0;
    mem_if.mem_ack  = 1'b0;
    mem_if.mem_data = '0;
    tick(3);

    // Reset values
    check("rst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
    check("rst_mem_addr", {10'd0, mem_if.mem_addr}, 32'd0);
    check("rst_m68k_ok", {31'd0, m68k_rom_ok}, 32'd0);
    check("rst_z80_ok", {31'd0, z80_rom_ok}, 32'd0);
    check("rst_m68k_dout", {16'd0, m68k_dout}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // 68000 miss, ack at cycle 4, then a hit on the same word
    m68k_rom_cs = 1'b1;
    m68k_addr   = 16'h0123;
    req_q.push_back(22'h000123);
    resp_q.push_back('{3, 16'hBEEF});
    m_q.push_back('{16'h0123, 16'hBEEF});
    tick(1);
    check("miss_req_c1", {31'd0, mem_if.mem_req}, 32'd1);
    tick(3);
    check("miss_req_c4", {31'd0, mem_if.mem_req}, 32'd1);
    tick(1);
    check("miss_req_c5", {31'd0, mem_if.mem_req}, 32'd0);
    check("miss_ok_c5", {31'd0, m68k_rom_ok}, 32'd1);
    check("miss_dout_c5", {16'd0, m68k_dout}, 32'h0000BEEF);
    tick(1);
    m68k_rom_cs = 1'b0;
    tick(2);
    m68k_rom_cs = 1'b1;
    m_q.push_back('{16'h0123, 16'hBEEF});
    tick(1);
    check("hit_ok_c1", {31'd0, m68k_rom_ok}, 32'd1);
    check("hit_no_req", {31'd0, mem_if.mem_req}, 32'd0);
    tick(2);
    m68k_rom_cs = 1'b0;
    tick(2);

    // Z80 byte select: odd byte fetched, even byte of the same word hits
    z80_rom_cs = 1'b1;
    z80_addr   = 16'h8001;
    req_q.push_back(22'h014000);
    resp_q.push_back('{1, 16'h12A5});
    z_q.push_back('{16'h8001, 16'h0012});
    tick(5);
    check("z80_odd_dout", {24'd0, z80_dout}, 32'h12);
    z80_addr = 16'h8000;
    z_q.push_back('{16'h8000, 16'h00A5});
    tick(1);
    check("z80_even_dout", {24'd0, z80_dout}, 32'hA5);
    tick(1);
    check("z80_even_ok", {31'd0, z80_rom_ok}, 32'd1);
    check("z80_even_no_req", {31'd0, mem_if.mem_req}, 32'd0);
    tick(2);
    z80_rom_cs = 1'b0;
    tick(2);

    // Simultaneous misses from reset: 68000 first, Z80 two cycles after the ack
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    req_rise_cyc.delete();
    ack_cyc.delete();
    m68k_rom_cs = 1'b1;
    m68k_addr   = 16'h0200;
    z80_rom_cs  = 1'b1;
    z80_addr    = 16'h0102;
    req_q.push_back(22'h000200);
    resp_q.push_back('{2, 16'h1111});
    req_q.push_back(22'h010081);
    resp_q.push_back('{0, 16'h2233});
    m_q.push_back('{16'h0200, 16'h1111});
    z_q.push_back('{16'h0102, 16'h0033});
    tick(8);
    check("b2b_req_count", req_rise_cyc.size(), 32'd2);
    if (req_rise_cyc.size() >= 2 && ack_cyc.size() >= 1) begin
      check("b2b_gap", req_rise_cyc[1] - ack_cyc[0], 32'd2);
    end

    // rr now names the 68000 after a solo 68000 miss, so the next tie goes to the Z80
    m68k_addr = 16'h0300;
    req_q.push_back(22'h000300);
    resp_q.push_back('{0, 16'h3030});
    m_q.push_back('{16'h0300, 16'h3030});
    tick(4);
    m68k_addr = 16'h0304;
    z80_addr  = 16'h0200;
    req_q.push_back(22'h010100);
    resp_q.push_back('{1, 16'h4040});
    req_q.push_back(22'h000304);
    resp_q.push_back('{0, 16'h5050});
    z_q.push_back('{16'h0200, 16'h0040});
    m_q.push_back('{16'h0304, 16'h5050});
    tick(1);
    check("rr_z80_first", {10'd0, mem_if.mem_addr}, 32'h00010100);
    tick(8);
    m68k_rom_cs = 1'b0;
    z80_rom_cs  = 1'b0;
    tick(2);

    // inval during a Z80 fetch: no ok, same address refetched; 68000 word now misses
    z80_rom_cs = 1'b1;
    z80_addr   = 16'h0400;
    req_q.push_back(22'h010200);
    resp_q.push_back('{3, 16'h5566});
    req_q.push_back(22'h010200);
    resp_q.push_back('{0, 16'h5566});
    z_q.push_back('{16'h0400, 16'h0066});
    tick(2);
    inval = 1'b1;
    tick(1);
    inval = 1'b0;
    tick(2);
    check("inval_z80_ok", {31'd0, z80_rom_ok}, 32'd0);
    check("inval_idle", {31'd0, mem_if.mem_req}, 32'd0);
    tick(1);
    check("inval_refetch", {31'd0, mem_if.mem_req}, 32'd1);
    tick(3);
    z80_rom_cs  = 1'b0;
    m68k_rom_cs = 1'b1;
    m68k_addr   = 16'h0304;
    req_q.push_back(22'h000304);
    resp_q.push_back('{0, 16'h7788});
    m_q.push_back('{16'h0304, 16'h7788});
    tick(1);
    check("inval_m68k_miss", {31'd0, m68k_rom_ok}, 32'd0);
    tick(4);
    m68k_rom_cs = 1'b0;
    tick(2);

    // 68000 address change mid-fetch
    m68k_rom_cs = 1'b1;
    m68k_addr   = 16'h0010;
    req_q.push_back(22'h000010);
    resp_q.push_back('{3, 16'hAAAA});
    req_q.push_back(22'h000020);
    resp_q.push_back('{1, 16'hBBBB});
    m_q.push_back('{16'h0020, 16'hBBBB});
    tick(2);
    m68k_addr = 16'h0020;
    tick(3);
    check("chg_first_ok", {31'd0, m68k_rom_ok}, 32'd0);
    tick(1);
    check("chg_second_req", {31'd0, mem_if.mem_req}, 32'd1);
    tick(4);
    check("chg_second_dout", {16'd0, m68k_dout}, 32'h0000BBBB);
    m68k_rom_cs = 1'b0;
    tick(2);

    // Reset mid-fetch; the late ack must not leave anything valid
    m68k_rom_cs = 1'b1;
    m68k_addr   = 16'h0500;
    req_q.push_back(22'h000500);
    resp_q.push_back('{3, 16'hCCCC});
    tick(2);
    check("rstmid_req_before", {31'd0, mem_if.mem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_req", {31'd0, mem_if.mem_req}, 32'd0);
    check("rstmid_m68k_ok", {31'd0, m68k_rom_ok}, 32'd0);
    check("rstmid_z80_ok", {31'd0, z80_rom_ok}, 32'd0);
    m68k_rom_cs = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(4);
    m68k_rom_cs = 1'b1;
    m68k_addr   = 16'h0500;
    z80_rom_cs  = 1'b1;
    z80_addr    = 16'h0400;
    req_q.push_back(22'h000500);
    resp_q.push_back('{0, 16'hDDDD});
    req_q.push_back(22'h010200);
    resp_q.push_back('{0, 16'hEEFF});
    m_q.push_back('{16'h0500, 16'hDDDD});
    z_q.push_back('{16'h0400, 16'h00FF});
    tick(1);
    check("rstpost_m68k_miss", {31'd0, m68k_rom_ok}, 32'd0);
    check("rstpost_z80_miss", {31'd0, z80_rom_ok}, 32'd0);
    tick(8);
    m68k_rom_cs = 1'b0;
    z80_rom_cs  = 1'b0;
    tick(3);

    // Everything expected must have been observed
    check("left_req", req_q.size(), 32'd0);
    check("left_resp", resp_q.size(), 32'd0);
    check("left_m68k", m_q.size(), 32'd0);
    check("left_z80", z_q.size(), 32'd0);
    check("left_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
